param_ping_pong_counter: RTL and testbench

PARAM_PING_PONG_COUNTER -- requirements
Module: param_ping_pong_counter

---
 rtl/param_ping_pong_counter.sv | 95 +++++++++
 tb/tb_param_ping_pong_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/param_ping_pong_counter.sv
// Bounded up/down counter that either bounces between min_val and max_val
// (ping-pong) or jumps to the opposite bound (wrap), with load, hold and flip.
module param_ping_pong_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             flip,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] out,
  output logic             direction,
  output logic             turn,
  output logic             at_min,
  output logic             at_max,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             turn_q, turn_d;
  logic             out_of_range;

  assign cfg_err      = (max_val < min_val);
  assign at_min       = (out_q == min_val);
  assign at_max       = (out_q == max_val);
  assign out_of_range = (out_q < min_val) || (out_q > max_val);

  assign out       = out_q;
  assign direction = dir_q;
  assign turn      = turn_q;

  // Next-state selection, highest priority first.
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    turn_d = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (!enable || cfg_err) begin
      out_d = out_q;
    end else if (out_of_range) begin
      out_d = min_val;
      dir_d = 1'b1;
    end else if (flip) begin
      dir_d = ~dir_q;
    end else if (min_val == max_val) begin
      out_d = out_q;
    end else if (dir_q) begin
      if (at_max) begin
        turn_d = 1'b1;
        if (mode) begin
          out_d = min_val;
        end else begin
          out_d = max_val - ONE;
          dir_d = 1'b0;
        end
      end else begin
        out_d = out_q + ONE;
      end
    end else begin
      if (at_min) begin
        turn_d = 1'b1;
        if (mode) begin
          out_d = max_val;
        end else begin
          out_d = min_val + ONE;
          dir_d = 1'b1;
        end
      end else begin
        out_d = out_q - ONE;
      end
    end
  end

  // Reset is named rst_n for legacy reasons but is active-high.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_q  <= '0;
      dir_q  <= 1'b1;
      turn_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      turn_q <= turn_d;
    end
  end

endmodule

// File: tb/tb_param_ping_pong_counter.sv
// Bench for param_ping_pong_counter: a reflection-based reference model checked
// every cycle, plus directed sequences with literal expected values.
module tb_param_ping_pong_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, enable, mode, flip, load;
  logic [W-1:0] load_val, min_val, max_val;
  logic [W-1:0] out;
  logic         direction, turn, at_min, at_max, cfg_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  int m_out, m_dir, m_turn;

  param_ping_pong_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .flip(flip),
    .load(load), .load_val(load_val), .min_val(min_val), .max_val(max_val),
    .out(out), .direction(direction), .turn(turn), .at_min(at_min),
    .at_max(at_max), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else pass_cnt++;
  endtask

  // Reference: try one step in the current direction; if it would leave the
  // range, either reflect (ping-pong) or jump to the opposite bound (wrap).
  always @(posedge clk) begin
    int lo, hi, step, nxt;
    lo = int'(min_val);
    hi = int'(max_val);
    m_turn = 0;
    if (rst_n) begin
      m_out = 0; m_dir = 1;
    end else if (load) begin
      m_out = int'(load_val);
    end else if (enable && hi >= lo) begin
      if (m_out < lo || m_out > hi) begin
        m_out = lo; m_dir = 1;
      end else if (flip) begin
        m_dir = 1 - m_dir;
      end else if (lo != hi) begin
        step = (m_dir == 1) ? 1 : -1;
        nxt  = m_out + step;
        if (nxt > hi || nxt < lo) begin
          m_turn = 1;
          if (mode) nxt = (m_dir == 1) ? lo : hi;
          else begin
            nxt   = m_out - step;
            m_dir = 1 - m_dir;
          end
        end
        m_out = nxt;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out", int'(out), m_out);
      chk("model_dir", int'(direction), m_dir);
      chk("model_turn", int'(turn), m_turn);
      chk("model_at_min", int'(at_min), int'(m_out == int'(min_val)));
      chk("model_at_max", int'(at_max), int'(m_out == int'(max_val)));
      chk("model_cfg_err", int'(cfg_err), int'(max_val < min_val));
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect3(input string nm, input int o, input int d, input int t);
    chk({nm, "_out"}, int'(out), o);
    chk({nm, "_dir"}, int'(direction), d);
    chk({nm, "_turn"}, int'(turn), t);
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; mode = 1'b0; flip = 1'b0; load = 1'b0;
    load_val = '0; min_val = 4'd0; max_val = 4'd15;
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    expect3("reset", 0, 1, 0);

    // Full-range ping-pong
    rst_n = 1'b0; enable = 1'b1;
    cyc(15);
    expect3("pp_top", 15, 1, 0);
    cyc(1);
    expect3("pp_rev_down", 14, 0, 1);
    cyc(14);
    expect3("pp_bottom", 0, 0, 0);
    cyc(1);
    expect3("pp_rev_up", 1, 1, 1);

    // Wrap up between 3 and 6
    rst_n = 1'b1; cyc(1); rst_n = 1'b0;
    min_val = 4'd3; max_val = 4'd6; mode = 1'b1;
    cyc(1);
    expect3("wrap_fix", 3, 1, 0);
    cyc(3);
    expect3("wrap_top", 6, 1, 0);
    cyc(1);
    expect3("wrap_jump", 3, 1, 1);
    cyc(1);
    expect3("wrap_after", 4, 1, 0);

    // Flip mid-run
    rst_n = 1'b1; cyc(1); rst_n = 1'b0;
    min_val = 4'd2; max_val = 4'd9; mode = 1'b0;
    cyc(4);
    expect3("flip_pre", 5, 1, 0);
    flip = 1'b1; cyc(1); flip = 1'b0;
    expect3("flip_hold", 5, 0, 0);
    cyc(3);
    expect3("flip_down", 2, 0, 0);
    cyc(1);
    expect3("flip_bounce", 3, 1, 1);

    // Load out of range, then corrected; load beats flip
    load = 1'b1; load_val = 4'd12; cyc(1); load = 1'b0;
    expect3("load12", 12, 1, 0);
    cyc(1);
    expect3("load_fix", 2, 1, 0);
    flip = 1'b1; cyc(1);
    expect3("flip_at_min", 2, 0, 0);
    load = 1'b1; load_val = 4'd7; cyc(1); load = 1'b0; flip = 1'b0;
    expect3("load_wins", 7, 0, 0);

    // Bad config freezes, equal bounds hold, disable freezes
    min_val = 4'd7; max_val = 4'd3; #1;
    chk("cfg_err_set", int'(cfg_err), 1);
    cyc(2);
    expect3("cfg_freeze", 7, 0, 0);
    min_val = 4'd5; max_val = 4'd5; load = 1'b1; load_val = 4'd5; cyc(1); load = 1'b0;
    cyc(2);
    expect3("eq_bounds", 5, 0, 0);
    chk("eq_at_min", int'(at_min), 1);
    chk("eq_at_max", int'(at_max), 1);
    enable = 1'b0; flip = 1'b1; min_val = 4'd0; max_val = 4'd15;
    cyc(3);
    expect3("disabled", 5, 0, 0);
    enable = 1'b1; flip = 1'b0;

    // Wrap downward past the minimum
    rst_n = 1'b1; cyc(1); rst_n = 1'b0;
    min_val = 4'd3; max_val = 4'd6; mode = 1'b1;
    cyc(1);
    flip = 1'b1; cyc(1); flip = 1'b0;
    expect3("wrapdn_flip", 3, 0, 0);
    cyc(1);
    expect3("wrapdn_jump", 6, 0, 1);
    cyc(1);
    expect3("wrapdn_after", 5, 0, 0);

    // Bounds moved under the counter
    min_val = 4'd1; max_val = 4'd4; cyc(1);
    expect3("bound_move", 1, 1, 0);

    // Reset during down-count with load asserted
    mode = 1'b0; min_val = 4'd0; max_val = 4'd15;
    load = 1'b1; load_val = 4'd8; cyc(1); load = 1'b0;
    flip = 1'b1; cyc(1); flip = 1'b0;
    cyc(1);
    expect3("pre_reset", 7, 0, 0);
    rst_n = 1'b1; load = 1'b1; load_val = 4'd12; cyc(1);
    rst_n = 1'b0; load = 1'b0;
    expect3("reset_wins", 0, 1, 0);
    cyc(1);
    expect3("post_reset", 1, 1, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
